ines_loader: RTL
================

Name: ines_loader

Overview:
Receiving end of the iNES byte stream that the ROM feeder pumps out as a byte plus a one-cycle strobe.
- Parses and validates the 16-byte header, skips an optional 512-byte trainer.
- Writes PRG and CHR bytes into the 22-bit game memory (PRG at 0x000000, CHR at 0x200000).
- Presents the cartridge configuration to the mapper logic, then signals done or error.

Parameters:
FIFO_DEPTH, 16, byte buffer entries between stream input and memory port (power of 2, >=4)
CHR_BASE, 22'h200000, memory address of first CHR byte

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high
indata  in  8  stream byte, valid when indata_clk=1
indata_clk  in  1  one-cycle byte strobe, may be high every cycle, no backpressure
mem_addr  out  22  write address
mem_data  out  8  write data
mem_write  out  1  write request, held with addr/data until accepted
mem_ready  in  1  memory accepts request in any cycle where mem_write & mem_ready
prg_banks  out  8  header byte 4 (16 KB units)
chr_banks  out  8  header byte 5 (8 KB units, 0 = CHR-RAM)
mapper  out  8  {flags7[7:4], flags6[7:4]}
mirroring  out  1  flags6[0]
battery  out  1  flags6[1]
four_screen  out  1  flags6[3]
done  out  1  sticky, image fully written
error  out  1  sticky, load aborted

Behaviour:
- Reset: all outputs 0, FIFO empty, state HDR, byte counter 0, write address 0.
- Input side: every strobed byte is pushed into the FIFO.
  - Strobe while FIFO full and no pop in the same cycle: overflow. Go to ERR; the byte is dropped.
  - Push and pop in the same cycle when full is legal.
- Parser consumes FIFO head. States:
  - HDR: pop one byte per cycle; capture bytes 4/5/6/7.
    - Bytes 0..3 must equal 4E 45 53 1A; on mismatch go to ERR as that byte is popped.
    - After byte 15: prg_banks==0 or prg_banks>128 -> ERR.
    - Else flags6[2] -> TRN, otherwise PRG.
    - Config outputs update as bytes are captured and stay valid until reset.
  - TRN: pop and discard 512 bytes, no memory writes, then PRG.
  - PRG: each byte goes to the memory port; address starts at 0 and increments per accepted write.
    - After prg_banks*16384 accepted writes: CHR if chr_banks!=0, else DONE.
  - CHR: address starts at CHR_BASE; after chr_banks*8192 accepted writes -> DONE.
  - DONE: done=1. Further strobes ignored (not pushed, no error).
  - ERR: error=1, mem_write=0. FIFO flushed, further strobes ignored. Only reset exits.
- Memory port:
  - mem_write/addr/data are registered.
  - Once raised, they hold stable until a cycle with mem_ready=1.
  - On that cycle the next FIFO byte may be loaded, so mem_write stays high: one write per clock at full rate.
  - mem_ready is ignored while mem_write=0.
- Latency: byte strobed at edge t appears on mem_data with mem_write=1 no later than edge t+2 when the FIFO was empty.
- Counters:
  - Remaining-byte counter is 23 bits (max 128*16384 = 2^21).
  - Address is 22 bits, no wrap possible within the legal range.
- done rises in the cycle after the final write is accepted.
- done and error are never both 1.
- Reset mid-load returns everything to reset values in one cycle; a replayed stream then loads cleanly.

Decomposition:
- Shared package:
  - iNES magic bytes
  - header length 16, trainer length 512
  - PRG unit 16384, CHR unit 8192
  - CHR_BASE default
  - state enum {HDR, TRN, PRG, CHR, DONE, ERR}
- One sub-module: byte_fifo.
  - Synchronous FIFO with FIFO_DEPTH x 8 storage, full/empty, push/pop, flush.
  - Same-cycle push+pop allowed when full.

Test Plan:
- Header 4E 45 53 1A 01 01 00 00 + 8x00, 24576 payload bytes strobed every cycle, mem_ready=1 -> 16384 writes at 0x000000..0x003FFF then 8192 at 0x200000..0x201FFF; data matches stream; done=1; mapper=0; error=0.
- Byte 3 = 1B instead of 1A -> error=1 after that byte is popped; mem_write never asserted; later strobes change nothing.
- flags6=0x04, prg_banks=1, chr_banks=0 -> first write carries stream byte 528 at addr 0; exactly 16384 writes; no address >=0x200000; done=1.
- flags6=0x41, flags7=0x20 -> mapper=0x24, mirroring=1, four_screen=0, battery=0.
- FIFO_DEPTH=16, continuous strobes, mem_ready held 0 from the first PRG write request -> error=1 on the strobe that finds the FIFO full; mem_write drops.
- Reset pulsed after 1000 PRG writes, then the full image replayed -> writes restart at addr 0; done=1; total writes 16384+8192 after reset.

Source files
------------

// File: rtl/ines_loader_pkg.sv
// ines_loader_pkg: iNES format constants, parser state encoding and magic-byte lookup
package ines_loader_pkg;
  localparam logic [31:0] MAGIC = 32'h4E45531A;
  localparam int HDR_LEN = 16;
  localparam int TRN_LEN = 512;
  localparam int PRG_UNIT = 16384;
  localparam int CHR_UNIT = 8192;
  localparam logic [21:0] CHR_BASE_DEF = 22'h200000;
  typedef enum logic [2:0] {HDR, TRN, PRG, CHR, DONE, ERR} state_t;
  function automatic logic [7:0] magic_byte(input logic [1:0] i);
    logic [31:0] m;
    m = MAGIC << {i, 3'b000};
    return m[31:24];
  endfunction
endpackage

// File: rtl/ines_loader_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with flush; push and pop may coincide even when full
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  input  logic       flush,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    rd_d = flush ? '0 : rd_q + AW'(pop);
    wr_d = flush ? '0 : wr_q + AW'(push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/ines_loader.sv
// ines_loader: parses an iNES byte stream and writes PRG/CHR data into game memory
module ines_loader
  import ines_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter logic [21:0] CHR_BASE = CHR_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  indata,
  input  logic        indata_clk,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic [7:0]  prg_banks,
  output logic [7:0]  chr_banks,
  output logic [7:0]  mapper,
  output logic        mirroring,
  output logic        battery,
  output logic        four_screen,
  output logic        done,
  output logic        error
);
  state_t state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [22:0] rem_q, rem_d;
  logic [21:0] nxt_q, nxt_d, addr_q, addr_d;
  logic [7:0] data_q, data_d, prg_q, prg_d, chr_q, chr_d, f6_q, f6_d;
  logic [3:0] f7_q, f7_d;
  logic wr_q, wr_d, done_q, done_d, error_q, error_d;
  logic [7:0] f_dout;
  logic f_full, f_empty, f_push, f_pop, f_flush;
  logic active, streaming, slot, overflow;
  assign active = state_q != DONE && state_q != ERR;
  assign streaming = state_q == PRG || state_q == CHR;
  assign slot = !wr_q || mem_ready;
  assign f_pop = (state_q == HDR || state_q == TRN) ? !f_empty
               : streaming && !f_empty && slot && rem_q != '0;
  assign overflow = indata_clk && active && f_full && !f_pop;
  assign f_push = indata_clk && active && (!f_full || f_pop);
  assign f_flush = state_q == ERR;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(f_push), .din(indata), .pop(f_pop),
    .flush(f_flush), .dout(f_dout), .full(f_full), .empty(f_empty)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    nxt_d = nxt_q;
    addr_d = addr_q;
    data_d = data_q;
    wr_d = wr_q;
    prg_d = prg_q;
    chr_d = chr_q;
    f6_d = f6_q;
    f7_d = f7_q;
    done_d = done_q;
    error_d = error_q;
    if (state_q == HDR && f_pop) begin
      cnt_d = cnt_q + 10'd1;
      if (cnt_q < 10'd4 && f_dout != magic_byte(cnt_q[1:0])) state_d = ERR;
      if (cnt_q == 10'd4) prg_d = f_dout;
      if (cnt_q == 10'd5) chr_d = f_dout;
      if (cnt_q == 10'd6) f6_d = f_dout;
      if (cnt_q == 10'd7) f7_d = f_dout[7:4];
      if (cnt_q == 10'(HDR_LEN - 1)) begin
        cnt_d = '0;
        nxt_d = '0;
        rem_d = 23'(prg_q) * 23'(PRG_UNIT);
        state_d = (prg_q == 8'd0 || prg_q > 8'd128) ? ERR : f6_q[2] ? TRN : PRG;
      end
    end
    if (state_q == TRN && f_pop) begin
      cnt_d = cnt_q + 10'd1;
      if (cnt_q == 10'(TRN_LEN - 1)) state_d = PRG;
    end
    if (streaming && wr_q && mem_ready) wr_d = 1'b0;
    if (streaming && f_pop) begin
      wr_d = 1'b1;
      addr_d = nxt_q;
      data_d = f_dout;
      nxt_d = nxt_q + 22'd1;
      rem_d = rem_q - 23'd1;
    end
    if (streaming && rem_q == '0 && slot) begin
      if (state_q == PRG && chr_q != 8'd0) begin
        state_d = CHR;
        rem_d = 23'(chr_q) * 23'(CHR_UNIT);
        nxt_d = CHR_BASE;
      end else begin
        state_d = DONE;
        done_d = 1'b1;
      end
    end
    if (overflow) state_d = ERR;
    if (state_d == ERR) begin
      error_d = 1'b1;
      done_d = 1'b0;
      wr_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HDR;
      cnt_q <= '0;
      rem_q <= '0;
      nxt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      prg_q <= '0;
      chr_q <= '0;
      f6_q <= '0;
      f7_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      nxt_q <= nxt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q <= wr_d;
      prg_q <= prg_d;
      chr_q <= chr_d;
      f6_q <= f6_d;
      f7_q <= f7_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_write = wr_q;
  assign prg_banks = prg_q;
  assign chr_banks = chr_q;
  assign mapper = {f7_q, f6_q[7:4]};
  assign mirroring = f6_q[0];
  assign battery = f6_q[1];
  assign four_screen = f6_q[3];
  assign done = done_q;
  assign error = error_q;
endmodule
